// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller: state encoding,
// default geometry and a counter-width helper.
package sar_pkg;

    localparam int RESOLUTION_DEF    = 8;
    localparam int SAMPLE_CYCLES_DEF = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_STORE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SAMPLE  = ST_SAMPLE,
        CONVERT = ST_CONVERT,
        STORE   = ST_STORE
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sar_if.sv
// Control/data bundle between the SAR controller, the analog front end and
// the sample FIFO write port.
interface sar_if
    import sar_pkg::*;
#(
    parameter int RESOLUTION = RESOLUTION_DEF
);
    logic                  en_i;
    logic                  start_i;
    logic                  cont_i;
    logic                  cmp_i;
    logic                  sample_o;
    logic [RESOLUTION-1:0] dac_code_o;
    logic                  busy_o;
    logic [RESOLUTION-1:0] wr_data_o;
    logic                  wr_en_o;
    logic                  full_i;
    logic                  overflow_o;
    logic                  clr_ovf_i;

    modport slave (
        input  en_i, start_i, cont_i, cmp_i, full_i, clr_ovf_i,
        output sample_o, dac_code_o, busy_o, wr_data_o, wr_en_o, overflow_o
    );

    modport master (
        output en_i, start_i, cont_i, cmp_i, full_i, clr_ovf_i,
        input  sample_o, dac_code_o, busy_o, wr_data_o, wr_en_o, overflow_o
    );
endinterface

// File: rtl/sar_bit_pointer.sv
// One-hot marker of the bit currently being decided; loads at the MSB and
// walks towards bit 0, which flags the final decision cycle.
module sar_bit_pointer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    output logic [WIDTH-1:0] ptr,
    output logic             last
);
    logic [WIDTH-1:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (clear) begin
            ptr_reg <= '0;
        end else if (load) begin
            ptr_reg <= {1'b1, {(WIDTH-1){1'b0}}};
        end else if (shift) begin
            ptr_reg <= ptr_reg >> 1;
        end
    end

    assign ptr  = ptr_reg;
    assign last = ptr_reg[0];
endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation sequencer: sample, binary search on the DAC code
// using comparator decisions, then hand the result to the FIFO write port.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int RESOLUTION    = RESOLUTION_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    sar_if.slave bus
);
    localparam int SCNT_W = clog2(SAMPLE_CYCLES);
    localparam logic [SCNT_W-1:0]     SCNT_LAST = SCNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [RESOLUTION-1:0] MIDSCALE  = {1'b1, {(RESOLUTION-1){1'b0}}};

    state_t                state_reg, state_next;
    logic [SCNT_W-1:0]     scnt_reg, scnt_next;
    logic [RESOLUTION-1:0] code_reg, code_next;
    logic [RESOLUTION-1:0] data_reg, data_next;
    logic                  ovf_reg, ovf_next;
    logic                  wr_strobe;
    logic [RESOLUTION-1:0] decided;
    logic [RESOLUTION-1:0] ptr;
    logic                  ptr_last;
    logic                  ptr_load;
    logic                  ptr_shift;
    logic                  ptr_clear;

    sar_bit_pointer #(
        .WIDTH (RESOLUTION)
    ) u_bit_pointer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ptr_load),
        .shift (ptr_shift),
        .clear (ptr_clear),
        .ptr   (ptr),
        .last  (ptr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            scnt_reg  <= '0;
            code_reg  <= '0;
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
            code_reg  <= code_next;
            data_reg  <= data_next;
            ovf_reg   <= ovf_next;
        end
    end

    // The comparator judged the code now on the DAC; a 0 rejects the trial bit.
    assign decided = bus.cmp_i ? code_reg : (code_reg & ~ptr);

    always_comb begin
        state_next = state_reg;
        scnt_next  = scnt_reg;
        code_next  = code_reg;
        data_next  = data_reg;
        ovf_next   = ovf_reg;
        wr_strobe  = 1'b0;
        ptr_load   = 1'b0;
        ptr_shift  = 1'b0;
        ptr_clear  = 1'b0;

        // Clear first so that a drop in the same cycle wins.
        if (bus.clr_ovf_i) begin
            ovf_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                code_next = '0;
                if (bus.en_i && (bus.start_i || bus.cont_i)) begin
                    state_next = SAMPLE;
                    scnt_next  = '0;
                end
            end
            SAMPLE: begin
                if (!bus.en_i) begin
                    state_next = IDLE;
                    scnt_next  = '0;
                end else if (scnt_reg == SCNT_LAST) begin
                    state_next = CONVERT;
                    scnt_next  = '0;
                    code_next  = MIDSCALE;
                    ptr_load   = 1'b1;
                end else begin
                    scnt_next = scnt_reg + SCNT_W'(1);
                end
            end
            CONVERT: begin
                if (!bus.en_i) begin
                    state_next = IDLE;
                    code_next  = '0;
                    ptr_clear  = 1'b1;
                end else begin
                    ptr_shift = 1'b1;
                    if (ptr_last) begin
                        state_next = STORE;
                        code_next  = decided;
                        data_next  = decided;
                    end else begin
                        code_next = decided | (ptr >> 1);
                    end
                end
            end
            STORE: begin
                code_next = '0;
                if (!bus.en_i) begin
                    state_next = IDLE;
                end else begin
                    if (bus.full_i) begin
                        ovf_next = 1'b1;
                    end else begin
                        wr_strobe = 1'b1;
                    end
                    state_next = bus.cont_i ? SAMPLE : IDLE;
                    scnt_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.sample_o   = (state_reg == SAMPLE);
    assign bus.busy_o     = (state_reg != IDLE);
    assign bus.dac_code_o = code_reg;
    assign bus.wr_data_o  = data_reg;
    assign bus.wr_en_o    = wr_strobe;
    assign bus.overflow_o = ovf_reg;
endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: an ideal comparator model drives cmp_i and a
// queue of expected codes is checked against every FIFO write.
module tb_sar_ctrl;
    import sar_pkg::*;

    localparam int RES   = 8;
    localparam int SC    = 4;
    localparam int STORE_C = SC + RES + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_if #(.RESOLUTION(RES)) bus ();

    sar_ctrl #(
        .RESOLUTION    (RES),
        .SAMPLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [RES-1:0] vin;
    assign bus.cmp_i = (bus.dac_code_o <= vin);

    int checks = 0;
    int errors = 0;
    logic [RES-1:0] exp_q[$];
    logic [RES-1:0] a5_seq [0:7] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_write(input string tag);
        chk({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk({tag, "_wr_data"}, 32'(bus.wr_data_o), 32'(exp_q.pop_front()));
    endtask

    // One single-shot conversion from IDLE with cycle-by-cycle checks.
    task automatic shot(input logic [RES-1:0] v);
        logic [RES-1:0] m;
        int b;
        vin = v;
        exp_q.push_back(v);
        m = {1'b1, {(RES-1){1'b0}}};
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        for (int c = 1; c <= STORE_C + 1; c++) begin
            chk("sample", 32'(bus.sample_o), 32'(c <= SC));
            chk("busy", 32'(bus.busy_o), 32'(c <= STORE_C));
            if (c > SC && c < STORE_C) begin
                b = SC + RES - c;
                chk("dac", 32'(bus.dac_code_o), 32'(m));
                if (v == 8'hA5) chk("dac_a5", 32'(bus.dac_code_o), 32'(a5_seq[c-SC-1]));
                m = ((m <= v) ? m : (m & ~(RES'(1) << b))) | ((b > 0) ? (RES'(1) << (b - 1)) : '0);
            end
            chk("wr_en", 32'(bus.wr_en_o), 32'(c == STORE_C));
            if (bus.wr_en_o) sb_write("shot");
            tick;
        end
        $display("shot vin=%0h done", v);
    endtask

    task automatic goto_store(input logic [RES-1:0] v);
        vin = v;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        repeat (SC + RES) tick;
    endtask

    logic [RES-1:0] vals [0:2] = '{8'h12, 8'h34, 8'h56};
    int k, last_c, nwr, nbusy;
    logic resample_due;

    initial begin
        bus.en_i = 1'b0; bus.start_i = 1'b0; bus.cont_i = 1'b0;
        bus.full_i = 1'b0; bus.clr_ovf_i = 1'b0;
        vin = '0;
        #12;
        chk("rst_sample", 32'(bus.sample_o), 0);
        chk("rst_dac", 32'(bus.dac_code_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_wr_data", 32'(bus.wr_data_o), 0);
        chk("rst_wr_en", 32'(bus.wr_en_o), 0);
        chk("rst_ovf", 32'(bus.overflow_o), 0);
        $display("reset checked");
        @(negedge clk);
        rst_n = 1'b1;
        bus.en_i = 1'b1;
        tick;

        shot(8'hA5);
        shot(8'hFF);
        shot(8'h00);

        // Continuous mode with a new input level after each write.
        k = 0; last_c = 0; resample_due = 1'b0;
        vin = vals[0];
        exp_q.push_back(vals[0]);
        bus.cont_i = 1'b1;
        tick;
        for (int c = 1; c <= 60 && k < 3; c++) begin
            if (resample_due) begin
                chk("cont_resample", 32'(bus.sample_o), 1);
                resample_due = 1'b0;
            end
            if (bus.wr_en_o) begin
                sb_write("cont");
                chk("cont_spacing", 32'(c - last_c), 32'(STORE_C));
                $display("cont write %0d at cycle %0d data=%0h", k, c, bus.wr_data_o);
                last_c = c;
                k++;
                if (k == 3) begin
                    bus.cont_i = 1'b0;
                end else begin
                    vin = vals[k];
                    exp_q.push_back(vals[k]);
                    resample_due = 1'b1;
                end
            end
            tick;
        end
        chk("cont_writes", 32'(k), 3);
        tick;
        chk("cont_idle", 32'(bus.busy_o), 0);

        // Drop on a full FIFO, then sticky behaviour and clear priority.
        bus.full_i = 1'b1;
        goto_store(8'h3C);
        chk("ovf_in_store", 32'(bus.busy_o), 1);
        chk("ovf_wr_en", 32'(bus.wr_en_o), 0);
        chk("ovf_pre", 32'(bus.overflow_o), 0);
        tick;
        chk("ovf_set", 32'(bus.overflow_o), 1);
        $display("overflow drop checked");
        goto_store(8'h3D);
        chk("ovf_sticky", 32'(bus.overflow_o), 1);
        chk("ovf_wr_en2", 32'(bus.wr_en_o), 0);
        bus.clr_ovf_i = 1'b1;
        tick;
        bus.clr_ovf_i = 1'b0;
        chk("ovf_set_wins", 32'(bus.overflow_o), 1);
        bus.clr_ovf_i = 1'b1;
        tick;
        bus.clr_ovf_i = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow_o), 0);
        bus.full_i = 1'b0;
        $display("overflow clear checked");

        // Enable dropped mid-CONVERT.
        vin = 8'h77;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        repeat (7) tick;
        bus.en_i = 1'b0;
        tick;
        chk("abort_busy", 32'(bus.busy_o), 0);
        chk("abort_dac", 32'(bus.dac_code_o), 0);
        nwr = 0;
        repeat (20) begin
            if (bus.wr_en_o) nwr++;
            tick;
        end
        chk("abort_no_write", 32'(nwr), 0);
        bus.en_i = 1'b1;
        $display("enable abort checked");

        // start_i during CONVERT must not queue a second conversion.
        vin = 8'h5A;
        exp_q.push_back(8'h5A);
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        repeat (6) tick;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        nwr = 0;
        repeat (40) begin
            if (bus.wr_en_o) begin
                nwr++;
                sb_write("ignore");
            end
            tick;
        end
        chk("ignore_one_write", 32'(nwr), 1);
        $display("start ignored checked");

        // Asynchronous reset in the middle of SAMPLE.
        vin = 8'hC3;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        tick;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", 32'(bus.sample_o), 0);
        chk("arst_busy", 32'(bus.busy_o), 0);
        chk("arst_dac", 32'(bus.dac_code_o), 0);
        chk("arst_wr_data", 32'(bus.wr_data_o), 0);
        chk("arst_wr_en", 32'(bus.wr_en_o), 0);
        chk("arst_ovf", 32'(bus.overflow_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        nbusy = 0;
        repeat (20) begin
            if (bus.busy_o) nbusy++;
            tick;
        end
        chk("arst_stays_idle", 32'(nbusy), 0);
        $display("async reset checked");
        shot(8'hC3);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
Successive-approximation control FSM for the SAR ADC. It sits directly upstream of the sample FIFO.
- Sequences the analog front end: sample switch, then binary-search DAC codes driven by comparator decisions.
- Pushes each finished code into the FIFO write port, honouring the FIFO's full flag.
- Supports single-shot and continuous conversion, with a sticky overflow flag for dropped samples.

Parameters:
RESOLUTION, 8, number of result bits and conversion cycles (valid range 2..16)
SAMPLE_CYCLES, 4, clock cycles sample_o is held high per conversion (valid range 1..255)

Ports:
clk  input  1  single clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
en_i  input  1  block enable; low aborts any conversion
start_i  input  1  single-cycle request for one conversion (sampled in IDLE only)
cont_i  input  1  continuous mode: auto-restart after each STORE while en_i high
cmp_i  input  1  comparator decision, already synchronous to clk; 1 = Vin >= Vdac
sample_o  output  1  track/hold switch control, high during SAMPLE
dac_code_o  output  RESOLUTION  trial code to capacitive DAC (registered)
busy_o  output  1  high in any state other than IDLE
wr_data_o  output  RESOLUTION  finished code, to FIFO wr_data_i
wr_en_o  output  1  one-cycle write strobe, to FIFO wr_en_i
full_i  input  1  FIFO full_o
overflow_o  output  1  sticky: a finished sample was dropped because full_i was high
clr_ovf_i  input  1  synchronous clear of overflow_o

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE.
- All outputs 0: sample_o, dac_code_o, busy_o, wr_data_o, wr_en_o, overflow_o.
- Internal counters 0.

States: IDLE, SAMPLE, CONVERT, STORE (registered state, binary encoding).

IDLE:
- Go to SAMPLE when en_i & (start_i | cont_i).
- Otherwise stay.

SAMPLE:
- sample_o = 1 and dac_code_o = 0.
- Lasts exactly SAMPLE_CYCLES cycles, counted by a sample counter, then go to CONVERT.

CONVERT:
- Runs exactly RESOLUTION cycles; bit index i counts from RESOLUTION-1 down to 0.
- On entry, dac_code_o = 1 << (RESOLUTION-1), i.e. midscale.
- In each cycle, cmp_i is evaluated against the code currently on dac_code_o.
  - If cmp_i = 1, bit i is kept; otherwise bit i is cleared.
  - The next trial code sets bit i-1.
- After bit 0 is decided, the result is latched into wr_data_o and the state moves to STORE.

STORE (one cycle):
- If full_i = 0: wr_en_o = 1 for this cycle, with wr_data_o valid.
- If full_i = 1: wr_en_o stays 0, the sample is dropped, and overflow_o is set.
- Next state:
  - SAMPLE if en_i & cont_i.
  - Otherwise IDLE, even if start_i is asserted during STORE.

Latency:
- start_i high in IDLE at cycle 0 gives sample_o high on cycles 1..SAMPLE_CYCLES.
- CONVERT occupies cycles SAMPLE_CYCLES+1 .. SAMPLE_CYCLES+RESOLUTION.
- wr_en_o is high on cycle SAMPLE_CYCLES+RESOLUTION+1.
- Continuous mode period is SAMPLE_CYCLES+RESOLUTION+1 cycles per sample.

Boundary conditions:
- start_i outside IDLE: ignored, not queued.
- en_i low in any non-IDLE state: the next state is IDLE, the partial result is discarded, wr_en_o stays 0, and dac_code_o returns to 0.
- en_i low takes priority over the STORE write, so no write occurs that cycle.
- overflow_o:
  - Set takes priority over clr_ovf_i in the same cycle.
  - It is cleared only by clr_ovf_i or rst_n; it is unaffected by en_i.
- wr_en_o never asserts while full_i is high, so the FIFO never sees a rejected write.
- rst_n asserted mid-conversion: immediate return to the reset values. After rst_n deasserts, the first conversion needs a fresh start_i, or cont_i with en_i.
- Code range: cmp_i always 1 gives all ones; cmp_i always 0 gives 0.

Decomposition:
- Package sar_pkg holds:
  - state encoding localparams (IDLE=0, SAMPLE=1, CONVERT=2, STORE=3);
  - default RESOLUTION and SAMPLE_CYCLES;
  - counter-width function clog2.
- No sub-module required; the FSM, sample counter, bit pointer and result register live in one module.
- Optional helper: sar_bit_pointer, a one-hot shift register marking the current bit, instantiated once.

Test Plan:
- Single shot, model Vin=0xA5 (cmp_i = code <= 0xA5), start_i at cycle 0:
  - dac_code_o sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
  - wr_en_o high only on cycle 13, with wr_data_o=0xA5.
- Extremes: Vin=0xFF gives 0xFF and Vin=0x00 gives 0x00; busy_o is high on cycles 1..13 and low on cycle 14.
- Continuous mode (cont_i=1, en_i=1) with a varying Vin sequence 0x12, 0x34, 0x56: three writes, each 13 cycles apart, with the correct codes; sample_o re-asserts on the cycle after each STORE.
- full_i=1 during STORE: wr_en_o stays 0 and overflow_o=1 on the next cycle. clr_ovf_i together with a new overflow leaves overflow_o=1; clr_ovf_i alone then gives 0.
- en_i dropped at cycle 8 (mid-CONVERT): IDLE on cycle 9, dac_code_o=0, no wr_en_o. start_i pulsed during CONVERT is ignored, so exactly one write occurs.
- rst_n pulsed low asynchronously mid-SAMPLE: all outputs go 0 without a clock edge, and the FSM stays in IDLE until the next start_i.
